// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU opcode constants and FSM encodings for mdu_ctrl, the decoder
// and the stall controller.
package mdu_ctrl_pkg;

  localparam logic [4:0] MDU_NONE  = 5'd0;
  localparam logic [4:0] MDU_MULT  = 5'd1;
  localparam logic [4:0] MDU_MULTU = 5'd2;
  localparam logic [4:0] MDU_DIV   = 5'd3;
  localparam logic [4:0] MDU_DIVU  = 5'd4;
  localparam logic [4:0] MDU_MTHI  = 5'd5;
  localparam logic [4:0] MDU_MTLO  = 5'd6;
  localparam logic [4:0] MDU_MFHI  = 5'd7;
  localparam logic [4:0] MDU_MFLO  = 5'd8;
  localparam logic [4:0] MDU_MADD  = 5'd9;
  localparam logic [4:0] MDU_MADDU = 5'd10;
  localparam logic [4:0] MDU_MSUB  = 5'd11;
  localparam logic [4:0] MDU_MSUBU = 5'd12;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Multiply-accumulate family (only legal when the MADD option is built in).
  function automatic logic is_madd_op(input logic [4:0] op);
    return (op == MDU_MADD) || (op == MDU_MADDU) ||
           (op == MDU_MSUB) || (op == MDU_MSUBU);
  endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: latches operands on a start, models
// latency with a 4-bit down counter, commits to HI/LO when it expires.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  E_MDU_op,
  input  logic [31:0] E_rs_val,
  input  logic [31:0] E_rt_val,
  input  logic        E_flush,
  output logic        E_busy,
  output logic        E_real_busy,
  output logic [31:0] E_MDU_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

`ifdef MDU_MADD_EN
  localparam logic MADD_EN = 1'b1;
`else
  localparam logic MADD_EN = 1'b0;
`endif

  logic [0:0]  state_p0;
  logic [3:0]  cnt_p0;
  logic [4:0]  op_p0;
  logic [31:0] rs_p0;
  logic [31:0] rt_p0;

  logic [4:0]  op_eff;
  logic        mult_start;
  logic        div_start;
  logic        start;
  logic        commit;

  logic signed [63:0] rs_sx;
  logic signed [63:0] rt_sx;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] rt_div_s;
  logic        [31:0] rt_div_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;
  logic        [63:0] hilo_nxt;

  // Effective opcode: flushed bubbles and disabled MADD opcodes act as no-op.
  always_comb begin
    op_eff = E_flush ? MDU_NONE : E_MDU_op;
    if (!MADD_EN && is_madd_op(op_eff)) op_eff = MDU_NONE;
  end

  // Start decode; only accepted while idle, anything arriving when busy is dropped.
  always_comb begin
    mult_start = (op_eff == MDU_MULT) || (op_eff == MDU_MULTU) || is_madd_op(op_eff);
    div_start  = (op_eff == MDU_DIV)  || (op_eff == MDU_DIVU);
    start      = (state_p0 == ST_IDLE) && (mult_start || div_start);
    commit     = (state_p0 == ST_BUSY) && (cnt_p0 == 4'd1);
    E_busy      = (cnt_p0 != 4'd0);
    E_real_busy = E_busy || start;
  end

  // mfhi/mflo are served straight from the architectural registers.
  always_comb begin
    case (op_eff)
      MDU_MFHI: E_MDU_out = HI;
      MDU_MFLO: E_MDU_out = LO;
      default:  E_MDU_out = 32'd0;
    endcase
  end

  // Result datapath from latched operands; divide by zero keeps HI/LO.
  always_comb begin
    rs_sx    = $signed({{32{rs_p0[31]}}, rs_p0});
    rt_sx    = $signed({{32{rt_p0[31]}}, rt_p0});
    prod_s   = rs_sx * rt_sx;
    prod_u   = {32'd0, rs_p0} * {32'd0, rt_p0};
    rt_div_u = (rt_p0 == 32'd0) ? 32'd1 : rt_p0;
    rt_div_s = $signed(rt_div_u);
    quo_s    = $signed(rs_p0) / rt_div_s;
    rem_s    = $signed(rs_p0) % rt_div_s;
    quo_u    = rs_p0 / rt_div_u;
    rem_u    = rs_p0 % rt_div_u;
    hilo_nxt = {HI, LO};
    case (op_p0)
      MDU_MULT:  hilo_nxt = prod_s;
      MDU_MULTU: hilo_nxt = prod_u;
      MDU_DIV:   if (rt_p0 != 32'd0) hilo_nxt = {rem_s, quo_s};
      MDU_DIVU:  if (rt_p0 != 32'd0) hilo_nxt = {rem_u, quo_u};
      MDU_MADD:  hilo_nxt = {HI, LO} + prod_s;
      MDU_MADDU: hilo_nxt = {HI, LO} + prod_u;
      MDU_MSUB:  hilo_nxt = {HI, LO} - prod_s;
      MDU_MSUBU: hilo_nxt = {HI, LO} - prod_u;
      default:   hilo_nxt = {HI, LO};
    endcase
  end

  // Control FSM: load latency on start, count down, return to idle on 1->0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= ST_IDLE;
      cnt_p0   <= 4'd0;
    end else if (state_p0 == ST_IDLE) begin
      if (start) begin
        cnt_p0   <= mult_start ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
        state_p0 <= ST_BUSY;
      end
    end else begin
      cnt_p0 <= cnt_p0 - 4'd1;
      if (cnt_p0 == 4'd1) state_p0 <= ST_IDLE;
    end
  end

  // Stage p0: operand/opcode capture at start (data, not reset).
  always_ff @(posedge clk) begin
    if (start) begin
      op_p0 <= op_eff;
      rs_p0 <= E_rs_val;
      rt_p0 <= E_rt_val;
    end
  end

  // HI/LO: commit at end of latency, mthi/mtlo only while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if (commit) begin
      HI <= hilo_nxt[63:32];
      LO <= hilo_nxt[31:0];
    end else if (state_p0 == ST_IDLE) begin
      if (op_eff == MDU_MTHI) HI <= E_rs_val;
      if (op_eff == MDU_MTLO) LO <= E_rs_val;
    end
  end

endmodule
